// File: rtl/decode_buffer_pkg.sv
// Shared constants and types for the decode buffer: opcodes, entry layout,
// and small opcode-classification helpers.
package decode_buffer_pkg;

    localparam int unsigned ROB_BIT_DEFAULT = 4;
    localparam int unsigned XLEN            = 32;
    localparam int unsigned REG_IDX_W       = 5;
    localparam int unsigned OPCODE_W        = 7;

    localparam logic [6:0] LUI       = 7'b0110111;
    localparam logic [6:0] AUIPC     = 7'b0010111;
    localparam logic [6:0] JAL       = 7'b1101111;
    localparam logic [6:0] JALR      = 7'b1100111;
    localparam logic [6:0] B_TYPE    = 7'b1100011;
    localparam logic [6:0] LD_TYPE   = 7'b0000011;
    localparam logic [6:0] S_TYPE    = 7'b0100011;
    localparam logic [6:0] ALGI_TYPE = 7'b0010011;
    localparam logic [6:0] R_TYPE    = 7'b0110011;

    // Where the head goes besides the ROB.
    typedef enum logic [1:0] {
        CLS_ROB = 2'd0,
        CLS_RS  = 2'd1,
        CLS_LSB = 2'd2
    } inst_class_e;

    // One decoded-instruction slot.
    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] imm;
        inst_class_e     cls;
    } entry_t;

    // Map an opcode to its downstream destination class.
    function automatic inst_class_e classify(input logic [6:0] op);
        inst_class_e c;
        case (op)
            ALGI_TYPE, R_TYPE, B_TYPE: c = CLS_RS;
            LD_TYPE, S_TYPE:           c = CLS_LSB;
            default:                   c = CLS_ROB;
        endcase
        return c;
    endfunction

    // Opcodes whose second operand is the immediate rather than rs2.
    function automatic logic has_no_rs2(input logic [6:0] op);
        logic r;
        case (op)
            LUI, AUIPC, JAL, JALR, LD_TYPE, ALGI_TYPE: r = 1'b1;
            default:                                   r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/decode_buffer_imm_gen.sv
// Combinational immediate generator applied to instructions as they enqueue.
module decode_buffer_imm_gen
    import decode_buffer_pkg::*;
(
    input  logic [31:0] inst,
    output logic [31:0] imm
);

    // Select the immediate format from the opcode.
    always_comb begin
        imm = 32'b0;
        case (inst[6:0])
            LUI, AUIPC: imm = {inst[31:12], 12'b0};
            JAL:        imm = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
            JALR,
            LD_TYPE:    imm = {{20{inst[31]}}, inst[31:20]};
            B_TYPE:     imm = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
            S_TYPE:     imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            ALGI_TYPE: begin
                if (inst[14:12] == 3'b001 || inst[14:12] == 3'b101)
                    imm = {27'b0, inst[24:20]};
                else
                    imm = {{20{inst[31]}}, inst[31:20]};
            end
            default:    imm = 32'b0;
        endcase
    end

endmodule

// File: rtl/decode_buffer.sv
// Decoded-instruction FIFO between the fetcher and ROB/RS/LSB issue.
// Entries carry a precomputed immediate and destination class; the head is
// decoded combinationally so issue happens in the same cycle it is eligible.
module decode_buffer
    import decode_buffer_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned ROB_BIT = ROB_BIT_DEFAULT
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               rdy_in,
    input  logic               flush,
    input  logic               fetch_valid,
    input  logic [31:0]        fetch_inst,
    input  logic [31:0]        fetch_addr,
    output logic               fetch_ready,
    input  logic               rob_full,
    input  logic               rs_full,
    input  logic               lsb_full,
    input  logic [ROB_BIT-1:0] rob_tail,
    output logic [4:0]         get_id1,
    output logic [4:0]         get_id2,
    input  logic [31:0]        val1,
    input  logic [31:0]        val2,
    input  logic               has_dep1_in,
    input  logic               has_dep2_in,
    input  logic [ROB_BIT-1:0] dep1,
    input  logic [ROB_BIT-1:0] dep2,
    output logic               issue_signal,
    output logic               issue_signal_rs,
    output logic               issue_signal_lsb,
    output logic [31:0]        imm,
    output logic [31:0]        reg1_v,
    output logic [31:0]        reg2_v,
    output logic               has_dep1,
    output logic               has_dep2,
    output logic [ROB_BIT-1:0] rob_entry1,
    output logic [ROB_BIT-1:0] rob_entry2,
    output logic [4:0]         rd_id,
    output logic [ROB_BIT-1:0] rd_rob,
    output logic [31:0]        inst_out,
    output logic [31:0]        inst_addr_out,
    output logic               jalr_stall
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    entry_t      mem [DEPTH];
    entry_t      new_entry;
    entry_t      head;
    logic [31:0] new_imm;
    logic        enq;
    logic        nonempty;
    logic        stall;
    logic        issue;
    logic        no_rs2;
    logic [6:0]  head_op;

    decode_buffer_imm_gen imm_gen (
        .inst (fetch_inst),
        .imm  (new_imm)
    );

    assign nonempty    = (count_q != CNT_W'(0));
    assign fetch_ready = (count_q < CNT_W'(DEPTH)) & ~flush;
    assign enq         = fetch_valid & fetch_ready & rdy_in;

    assign head    = mem[head_q];
    assign head_op = head.inst[6:0];
    assign no_rs2  = has_no_rs2(head_op);
    assign stall   = nonempty & (head_op == JALR) & has_dep1_in;
    assign issue   = nonempty & ~flush & ~stall & ~rob_full & ~rs_full & ~lsb_full & rdy_in;

    assign new_entry = '{inst: fetch_inst, addr: fetch_addr, imm: new_imm,
                         cls: classify(fetch_inst[6:0])};

    // Next pointer/count state; flush empties the buffer and wins over enqueue/issue.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (enq)
                tail_d = tail_q + PTR_W'(1);
            if (issue)
                head_d = head_q + PTR_W'(1);
            case ({enq, issue})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer/count registers; everything holds while rdy_in is low.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (rdy_in) begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage; contents are only observed through a nonzero count.
    always_ff @(posedge clk_in) begin
        if (enq)
            mem[tail_q] <= new_entry;
    end

    // Head decode and issue outputs, all zero while empty.
    always_comb begin
        get_id1          = 5'b0;
        get_id2          = 5'b0;
        issue_signal     = 1'b0;
        issue_signal_rs  = 1'b0;
        issue_signal_lsb = 1'b0;
        imm              = 32'b0;
        reg1_v           = 32'b0;
        reg2_v           = 32'b0;
        has_dep1         = 1'b0;
        has_dep2         = 1'b0;
        rob_entry1       = '0;
        rob_entry2       = '0;
        rd_id            = 5'b0;
        inst_out         = 32'b0;
        inst_addr_out    = 32'b0;
        jalr_stall       = 1'b0;
        if (nonempty) begin
            get_id1          = head.inst[19:15];
            get_id2          = head.inst[24:20];
            issue_signal     = issue;
            issue_signal_rs  = issue & (head.cls == CLS_RS);
            issue_signal_lsb = issue & (head.cls == CLS_LSB);
            imm              = head.imm;
            reg1_v           = val1;
            has_dep1         = has_dep1_in;
            rob_entry1       = dep1;
            reg2_v           = no_rs2 ? head.imm : val2;
            has_dep2         = no_rs2 ? 1'b0 : has_dep2_in;
            rob_entry2       = no_rs2 ? '0 : dep2;
            rd_id            = (head_op == B_TYPE || head_op == S_TYPE) ? 5'b0 : head.inst[11:7];
            inst_out         = head.inst;
            inst_addr_out    = head.addr;
            jalr_stall       = stall;
        end
    end

    assign rd_rob = rob_tail;

endmodule

// File: tb/tb_decode_buffer.sv
// Directed self-checking bench for decode_buffer (DEPTH=4, ROB_BIT=4).
module tb_decode_buffer;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        flush;
    logic        fetch_valid;
    logic [31:0] fetch_inst;
    logic [31:0] fetch_addr;
    logic        fetch_ready;
    logic        rob_full, rs_full, lsb_full;
    logic [3:0]  rob_tail;
    logic [4:0]  get_id1, get_id2;
    logic [31:0] val1, val2;
    logic        has_dep1_in, has_dep2_in;
    logic [3:0]  dep1, dep2;
    logic        issue_signal, issue_signal_rs, issue_signal_lsb;
    logic [31:0] imm, reg1_v, reg2_v;
    logic        has_dep1, has_dep2;
    logic [3:0]  rob_entry1, rob_entry2;
    logic [4:0]  rd_id;
    logic [3:0]  rd_rob;
    logic [31:0] inst_out, inst_addr_out;
    logic        jalr_stall;

    int n_assert = 0;
    int n_fail   = 0;

    decode_buffer #(.DEPTH(4), .ROB_BIT(4)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
        .fetch_valid(fetch_valid), .fetch_inst(fetch_inst), .fetch_addr(fetch_addr),
        .fetch_ready(fetch_ready), .rob_full(rob_full), .rs_full(rs_full),
        .lsb_full(lsb_full), .rob_tail(rob_tail), .get_id1(get_id1), .get_id2(get_id2),
        .val1(val1), .val2(val2), .has_dep1_in(has_dep1_in), .has_dep2_in(has_dep2_in),
        .dep1(dep1), .dep2(dep2), .issue_signal(issue_signal),
        .issue_signal_rs(issue_signal_rs), .issue_signal_lsb(issue_signal_lsb),
        .imm(imm), .reg1_v(reg1_v), .reg2_v(reg2_v), .has_dep1(has_dep1),
        .has_dep2(has_dep2), .rob_entry1(rob_entry1), .rob_entry2(rob_entry2),
        .rd_id(rd_id), .rd_rob(rd_rob), .inst_out(inst_out),
        .inst_addr_out(inst_addr_out), .jalr_stall(jalr_stall)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    function automatic logic [31:0] addi(input int k);
        return (32'(k) << 20) | (32'(k) << 7) | 32'h13;
    endfunction

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; flush = 1'b0; fetch_valid = 1'b0;
        fetch_inst = 32'h0; fetch_addr = 32'h0;
        rob_full = 1'b0; rs_full = 1'b0; lsb_full = 1'b0; rob_tail = 4'd7;
        val1 = 32'hAAAA_0001; val2 = 32'h0000_1234;
        has_dep1_in = 1'b0; has_dep2_in = 1'b1; dep1 = 4'd3; dep2 = 4'd5;

        // Reset state
        step();
        #1;
        chk("rst_fetch_ready", 32'(fetch_ready), 32'd1);
        chk("rst_issue", 32'(issue_signal), 32'd0);
        chk("rst_inst_out", inst_out, 32'h0);
        chk("rst_imm", imm, 32'h0);
        chk("rst_rd_rob", 32'(rd_rob), 32'd7);
        rst_in = 1'b0;

        // ADDI x1,x0,-1
        step();
        fetch_valid = 1'b1; fetch_inst = 32'hFFF00093; fetch_addr = 32'h100;
        #1;
        chk("addi_pre_ready", 32'(fetch_ready), 32'd1);
        chk("addi_pre_issue", 32'(issue_signal), 32'd0);
        step();
        fetch_valid = 1'b0;
        #1;
        chk("addi_issue", 32'(issue_signal), 32'd1);
        chk("addi_issue_rs", 32'(issue_signal_rs), 32'd1);
        chk("addi_issue_lsb", 32'(issue_signal_lsb), 32'd0);
        chk("addi_imm", imm, 32'hFFFFFFFF);
        chk("addi_reg2_v", reg2_v, 32'hFFFFFFFF);
        chk("addi_has_dep2", 32'(has_dep2), 32'd0);
        chk("addi_rd_id", 32'(rd_id), 32'd1);
        chk("addi_addr", inst_addr_out, 32'h100);
        step();
        #1;
        chk("addi_drained", 32'(issue_signal), 32'd0);
        chk("addi_drained_inst", inst_out, 32'h0);

        // SLLI then SW back to back
        fetch_valid = 1'b1; fetch_inst = 32'h00511113; fetch_addr = 32'h200;
        step();
        fetch_inst = 32'h00112623; fetch_addr = 32'h204;
        #1;
        chk("slli_imm", imm, 32'd5);
        chk("slli_rd", 32'(rd_id), 32'd2);
        chk("slli_rs", 32'(issue_signal_rs), 32'd1);
        chk("slli_id1", 32'(get_id1), 32'd2);
        step();
        fetch_valid = 1'b0;
        #1;
        chk("sw_imm", imm, 32'd12);
        chk("sw_rd", 32'(rd_id), 32'd0);
        chk("sw_lsb", 32'(issue_signal_lsb), 32'd1);
        chk("sw_rs", 32'(issue_signal_rs), 32'd0);
        chk("sw_id2", 32'(get_id2), 32'd1);
        chk("sw_reg2_v", reg2_v, 32'h1234);
        chk("sw_has_dep2", 32'(has_dep2), 32'd1);
        chk("sw_rob_entry2", 32'(rob_entry2), 32'd5);
        step();

        // Fill to DEPTH while RS is full, then drain in order
        rs_full = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            fetch_valid = 1'b1; fetch_inst = addi(k); fetch_addr = 32'h300 + 32'(k);
            #1;
            chk("fill_ready", 32'(fetch_ready), 32'd1);
            step();
        end
        fetch_inst = addi(5);
        #1;
        chk("full_ready", 32'(fetch_ready), 32'd0);
        chk("full_issue", 32'(issue_signal), 32'd0);
        chk("full_head", inst_out, addi(1));
        step();
        rs_full = 1'b0;
        #1;
        chk("full_issue_ready", 32'(fetch_ready), 32'd0);
        chk("full_issue_go", 32'(issue_signal), 32'd1);
        step();
        fetch_valid = 1'b0;
        for (int k = 2; k <= 4; k++) begin
            #1;
            chk("drain_inst", inst_out, addi(k));
            chk("drain_imm", imm, 32'(k));
            chk("drain_issue", 32'(issue_signal), 32'd1);
            step();
        end
        #1;
        chk("wrap_empty_issue", 32'(issue_signal), 32'd0);
        chk("wrap_empty_ready", 32'(fetch_ready), 32'd1);
        chk("wrap_empty_inst", inst_out, 32'h0);

        // JALR x1,8(x5) held by an rs1 dependency
        has_dep1_in = 1'b1;
        fetch_valid = 1'b1; fetch_inst = 32'h008280E7; fetch_addr = 32'h400;
        step();
        fetch_valid = 1'b0;
        #1;
        chk("jalr_stall", 32'(jalr_stall), 32'd1);
        chk("jalr_no_issue", 32'(issue_signal), 32'd0);
        chk("jalr_id1", 32'(get_id1), 32'd5);
        chk("jalr_rob_entry1", 32'(rob_entry1), 32'd3);
        chk("jalr_reg2_v", reg2_v, 32'd8);
        step();
        #1;
        chk("jalr_still_stall", 32'(issue_signal), 32'd0);
        has_dep1_in = 1'b0;
        #1;
        chk("jalr_release_stall", 32'(jalr_stall), 32'd0);
        chk("jalr_release_issue", 32'(issue_signal), 32'd1);
        chk("jalr_release_rs", 32'(issue_signal_rs), 32'd0);
        step();
        #1;
        chk("jalr_drained", 32'(issue_signal), 32'd0);

        // rdy_in low freezes state and blocks enqueue
        fetch_valid = 1'b1; fetch_inst = addi(6);
        step();
        rdy_in = 1'b0; fetch_inst = addi(7);
        #1;
        chk("rdy_low_issue", 32'(issue_signal), 32'd0);
        step();
        step();
        rdy_in = 1'b1; fetch_valid = 1'b0;
        #1;
        chk("rdy_high_head", inst_out, addi(6));
        chk("rdy_high_issue", 32'(issue_signal), 32'd1);
        step();
        #1;
        chk("rdy_no_enq", 32'(issue_signal), 32'd0);

        // Flush with three entries and a concurrent fetch
        rs_full = 1'b1;
        for (int k = 8; k <= 10; k++) begin
            fetch_valid = 1'b1; fetch_inst = addi(k);
            step();
        end
        rs_full = 1'b0; flush = 1'b1; fetch_inst = addi(11);
        #1;
        chk("flush_ready", 32'(fetch_ready), 32'd0);
        chk("flush_issue", 32'(issue_signal), 32'd0);
        step();
        flush = 1'b0; fetch_valid = 1'b0;
        #1;
        chk("post_flush_issue", 32'(issue_signal), 32'd0);
        chk("post_flush_inst", inst_out, 32'h0);
        chk("post_flush_ready", 32'(fetch_ready), 32'd1);
        fetch_valid = 1'b1; fetch_inst = addi(12);
        step();
        fetch_valid = 1'b0;
        #1;
        chk("post_flush_head", inst_out, addi(12));
        step();

        // Asynchronous reset mid-issue with two entries
        rs_full = 1'b1;
        for (int k = 13; k <= 14; k++) begin
            fetch_valid = 1'b1; fetch_inst = addi(k);
            step();
        end
        fetch_valid = 1'b0; rs_full = 1'b0;
        #1;
        chk("pre_rst_issue", 32'(issue_signal), 32'd1);
        #1;
        rst_in = 1'b1;
        #1;
        chk("async_rst_issue", 32'(issue_signal), 32'd0);
        chk("async_rst_inst", inst_out, 32'h0);
        chk("async_rst_ready", 32'(fetch_ready), 32'd1);
        rst_in = 1'b0;
        #1;
        chk("post_rst_issue", 32'(issue_signal), 32'd0);
        step();
        #1;
        chk("post_rst_edge_issue", 32'(issue_signal), 32'd0);
        chk("post_rst_edge_rs", 32'(issue_signal_rs), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
